// File: rtl/sample_in_ball_ctrl.sv
// rtl/sample_in_ball_ctrl.sv - ML-DSA SampleInBall sign capture, rejection filter and in-place swap engine

// Rejection filter: passes a sample byte only when it does not exceed the bound.
module sample_in_ball (
  input  logic       valid_i,
  input  logic [7:0] data_i,
  input  logic [7:0] rej_value_i,
  output logic       valid_o,
  output logic [7:0] data_o
);

  // Unsigned 8-bit compare j <= i; the sample index passes through unchanged.
  always_comb begin
    valid_o = valid_i && (data_i <= rej_value_i);
    data_o  = data_i;
  end

endmodule

module sample_in_ball_ctrl #(
  parameter int TAU = 60
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       zeroize_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  input  logic [7:0] data_i,
  output logic       data_ready_o,
  output logic       done_o,
  input  logic [7:0] rd_addr_i,
  output logic [1:0] rd_data_o
);

  typedef enum logic [1:0] {IDLE, SIGN, SAMPLE, DONE} state_t;

  // First index of the running bound; the sign index is i minus this value.
  localparam logic [7:0] I_START = 8'(256 - TAU);

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  c [256];
  logic [63:0] sign;
  logic [7:0]  idx;
  logic [2:0]  scnt;
  logic        accept;
  logic        filt_valid;
  logic [7:0]  filt_j;
  logic [5:0]  sidx;
  logic [1:0]  coef_new;

  // Ready and done depend on state only, never on the valid input.
  assign data_ready_o = (state_q == SIGN) || (state_q == SAMPLE);
  assign done_o       = (state_q == DONE);
  assign accept       = data_valid_i && data_ready_o;

  // Modulo-64 difference is exact because i - I_START stays within 0..TAU-1.
  assign sidx     = idx[5:0] - I_START[5:0];
  assign coef_new = sign[sidx] ? 2'b11 : 2'b01;

  sample_in_ball u_filter (
    .valid_i     (accept && (state_q == SAMPLE)),
    .data_i      (data_i),
    .rej_value_i (idx),
    .valid_o     (filt_valid),
    .data_o      (filt_j)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; zeroize overrides start, start overrides any byte accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      SIGN:    if (accept && (scnt == 3'd7)) state_d = SAMPLE;
      SAMPLE:  if (filt_valid && (idx == 8'hFF)) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (start_i) state_d = SIGN;
    if (zeroize_i) state_d = IDLE;
  end

  // Coefficient storage, sign register, counters and the registered read port.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int k = 0; k < 256; k++) c[k] <= 2'b00;
      sign      <= '0;
      idx       <= '0;
      scnt      <= '0;
      rd_data_o <= 2'b00;
    end else if (zeroize_i) begin
      for (int k = 0; k < 256; k++) c[k] <= 2'b00;
      sign      <= '0;
      idx       <= '0;
      scnt      <= '0;
      rd_data_o <= 2'b00;
    end else begin
      rd_data_o <= c[rd_addr_i];
      if (start_i) begin
        for (int k = 0; k < 256; k++) c[k] <= 2'b00;
        sign <= '0;
        scnt <= '0;
        idx  <= I_START;
      end else if (accept && (state_q == SIGN)) begin
        sign[{scnt, 3'b000} +: 8] <= data_i;
        scnt                      <= scnt + 3'd1;
      end else if (filt_valid) begin
        // Later assignment wins, so j == i leaves the signed value at c[i].
        c[idx]    <= c[filt_j];
        c[filt_j] <= coef_new;
        if (idx != 8'hFF) idx <= idx + 8'd1;
      end
    end
  end

endmodule

// File: doc/sample_in_ball_ctrl.md
# sample_in_ball_ctrl

Control and storage engine for ML-DSA SampleInBall. Consumes the SHAKE256 byte stream. Captures the 64 sign bits from the first 8 bytes. Drives the running index `i` as the rejection bound into a `sample_in_ball` filter instance, and performs the in-place swap on an internal 256-entry ternary challenge polynomial `c`. Downstream NTT/multiply logic reads `c` through a registered read port once `done_o` is asserted.

## Interface
- `TAU`, default 60: number of nonzero coefficients, valid range 1..64.
- `clk`  in  1  clock.
- `rst_b`  in  1  asynchronous active-low reset.
- `zeroize_i`  in  1  synchronous clear of all state and storage; returns to IDLE.
- `start_i`  in  1  single-cycle pulse; begins a new challenge from any state.
- `data_valid_i`  in  1  input byte valid.
- `data_i`  in  8  SHAKE256 output byte.
- `data_ready_o`  out  1  byte accepted on `data_valid_i & data_ready_o`.
- `done_o`  out  1  `c` complete; level, held until next `start_i`/`zeroize_i`.
- `rd_addr_i`  in  8  coefficient read index.
- `rd_data_o`  out  2  coefficient at `rd_addr_i` from the previous cycle: 00 = 0, 01 = +1, 11 = −1 (10 never produced).

## Operation
- State `c`: 256 × 2-bit registers. `sign`: 64-bit register. `i`: 8-bit index. `scnt`: 3-bit sign-byte counter. FSM: IDLE, SIGN, SAMPLE, DONE.
- IDLE: `data_ready_o`=0, `done_o`=0. On `start_i`, go to SIGN. Clear every `c[k]` to 00, `sign` to 0, `scnt` to 0, and set `i` to 256−TAU.
- SIGN: `data_ready_o`=1. Each accepted byte k (k = 0..7) is written to `sign[8k+7:8k]`, so storage is little-endian. After the 8th accept, go to SAMPLE.
- SAMPLE: `data_ready_o`=1. Each accepted byte is sample `j` and drives the filter with `valid_i`=accept, `data_i`=j, `rej_value_i`=i.
  - Filter `valid_o`=0 (j > i): byte dropped, no state change.
  - Filter `valid_o`=1: on the same edge, `c[i]` ← old `c[j]`, then `c[j]` ← ±1.
    - The sign bit is `sign[i − (256−TAU)]`: 0 gives +1 (01), 1 gives −1 (11).
    - When j == i, the `c[j]` write takes priority, so `c[i]` = ±1.
    - If i == 255, go to DONE. Otherwise i ← i+1.
- DONE: `data_ready_o`=0, `done_o`=1. `c` is frozen. Extra input bytes are not accepted.
- `start_i` in SIGN, SAMPLE or DONE aborts the current run and reinitialises exactly as from IDLE. It has priority over a simultaneous byte accept, and that byte is discarded.
- `zeroize_i` has priority over `start_i`. It clears `c`, `sign`, `i`, `scnt` and `rd_data_o`, then goes to IDLE.
- Arithmetic:
  - `i` never wraps; the i==255 accept terminates the run.
  - The sign index `i−(256−TAU)` spans 0..TAU−1, using 6 bits.
  - The comparison j ≤ i is unsigned 8-bit.
- Invariant at DONE: exactly TAU entries of `c` are nonzero.
- Reads are permitted in any state. They return the current register contents and are not gated by `done_o`.

## Timing
- Reset values: `data_ready_o`=0, `done_o`=0, `rd_data_o`=00. All `c`=00, `sign`=0, `i`=0, state IDLE.
- `start_i` at cycle t gives `data_ready_o`=1 from cycle t+1.
- 8 accepted sign bytes, then SAMPLE with `data_ready_o` still 1 and no bubble.
- Swap latency is 1 cycle. `c` is updated at the edge ending the accept cycle, so a back-to-back accept sees the updated `c` and the incremented `i`.
- Throughput is 1 byte/cycle. `data_ready_o` is a function of state only and does not depend on `data_valid_i`.
- The final accepted sample at cycle t gives `done_o`=1 at t+1 and `data_ready_o`=0 at t+1.
- Read latency is 1 cycle: `rd_addr_i` at t gives `rd_data_o` at t+1.
- Best case, with no rejections, is start + 8 + TAU cycles to `done_o`.

## Test plan
- Sign/identity: TAU=60, sign bytes 8×0x00, samples 196,197,…,255 (j == i each time) → `done_o` 1 cycle after the 68th byte. `c[196..255]`=01 and `c[0..195]`=00.
- Rejection: at i=196, bytes 200, 255, 197 are dropped with `i` staying 196 and no `c` change. Then byte 5 → `c[196]`=00 and `c[5]`=01 (sign0=0), or 11 with `sign[0]`=1 (byte0=0x01).
- Swap chain: TAU=60, sign byte0=0x02. Samples 10, then 10 → `c[196]`=00, then `c[197]`=01 (old `c[10]`) and `c[10]`=11.
- Backpressure/gaps: random `data_valid_i` idle cycles between bytes → final `c` identical to the gap-free run. No accept while `data_ready_o`=0 in IDLE or DONE.
- Abort/restart: `start_i` during SAMPLE at i=220 with a simultaneous valid byte → byte discarded, `c` all 00, next accepted byte lands in `sign[7:0]`. A second run completes correctly.
- Reset/zeroize: `rst_b` low mid-SIGN and `zeroize_i` mid-SAMPLE → all outputs 00/0 the next cycle, IDLE. Random full runs compared against a golden SampleInBall model, checking exactly TAU nonzero entries.
